// File: rtl/ram_fill_writer_pkg.sv
// Shared types and constants for the RAM fill writer: FSM encoding, default
// widths and the capacity helper used to clamp the requested fill length.
package ram_fill_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_AWIDTH = 10;
    localparam int DEF_DWIDTH = 32;
    localparam int LEN_WIDTH  = 32;

    // Number of words addressable with awidth address bits (2^awidth).
    function automatic logic [LEN_WIDTH-1:0] capacity(input int unsigned awidth);
        return {{(LEN_WIDTH-1){1'b0}}, 1'b1} << awidth;
    endfunction

endpackage

// File: rtl/ram_fill_writer_if.sv
// Stream input and RAM write port of the fill writer, grouped as one bundle.
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
// in_ready never depends combinationally on in_valid.
interface ram_fill_writer_if
    import ram_fill_writer_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
);

    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [AWIDTH-1:0] write_addr;
    logic [DWIDTH-1:0] write_data;

    // Source/RAM side of the bundle.
    modport master (
        output in_data, in_valid,
        input  in_ready, we, write_addr, write_data
    );

    // Writer side of the bundle.
    modport slave (
        input  in_data, in_valid,
        output in_ready, we, write_addr, write_data
    );

endinterface

// File: rtl/ram_fill_writer.sv
// Fills a single-port RAM from a valid/ready stream at addresses 0..len_eff-1
// and keeps a wrapping sum of every word written in the current fill.
module ram_fill_writer
    import ram_fill_writer_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    ram_fill_writer_if.slave     bus,
    output logic                 done,
    output logic [DWIDTH-1:0]    checksum,
    output state_t               dbg_state
);

    localparam logic [LEN_WIDTH-1:0] CAPACITY = capacity(AWIDTH);
    localparam logic [AWIDTH:0]      CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next_state;
    logic [AWIDTH:0]     r_count;
    logic [AWIDTH:0]     r_len_eff;
    logic [DWIDTH-1:0]   r_checksum;
    logic                r_we;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_data;

    logic [AWIDTH:0]     w_len_eff;
    logic                w_start_ok;
    logic                w_in_ready;
    logic                w_accept;

    // Clamp so addresses never wrap inside a fill.
    assign w_len_eff  = (len > CAPACITY) ? CAPACITY[AWIDTH:0] : len[AWIDTH:0];
    assign w_start_ok = start && (r_state != ST_WRITE);
    assign w_in_ready = (r_state == ST_WRITE) && (r_count < r_len_eff);
    assign w_accept   = w_in_ready && bus.in_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = (w_len_eff == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Reached one cycle after the final accept, i.e. while the last we is out.
                if (r_count == r_len_eff) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_len_eff  <= '0;
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_count    <= '0;
            r_len_eff  <= w_len_eff;
            r_checksum <= '0;
        end else if (w_accept) begin
            r_count    <= r_count + CNT_ONE;
            r_checksum <= r_checksum + bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr <= r_count[AWIDTH-1:0];
                r_data <= bus.in_data;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.we         = r_we;
    assign bus.write_addr = r_addr;
    assign bus.write_data = r_data;
    assign done           = (r_state == ST_DONE);
    assign checksum       = r_checksum;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_ram_fill_writer.sv
// Directed bench for ram_fill_writer: reset checks, a table of fills with
// hand-computed results, and a write scoreboard backed by a RAM model.
module tb_ram_fill_writer;
  import ram_fill_writer_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic [31:0]      len;
    logic [3:0][31:0] data;       // [0] is the first beat
    logic [7:0]       pat;        // in_valid for cycles 1..8 after start, LSB first
    int               restart_at; // cycle index to pulse start (with len 1), 0 = never
    int               exp_writes;
    logic [31:0]      exp_sum;
    int               exp_cycles; // start edge to first cycle with done = 1
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   len_in;
  logic          done;
  logic [DW-1:0] checksum;
  state_t        dbg_state;

  ram_fill_writer_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  ram_fill_writer #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len_in),
    .bus       (bus),
    .done      (done),
    .checksum  (checksum),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.we === 1'b1) mem[bus.write_addr] <= bus.write_data;
  end

  // ---------------- scoreboard ----------------
  int n_tests  = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [3:0][31:0] cur_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [AW+DW-1:0] e;
    if (bus.we === 1'b1) begin
      n_writes++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                 bus.write_addr, bus.write_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.write_addr, bus.write_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.write_addr, bus.write_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  function automatic logic [31:0] word(input int i);
    if (i < 4) return cur_data[i];
    return 32'h1000 + 32'(i);
  endfunction

  task automatic push_exp(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = i[AW-1:0];
      exp_q.push_back({a, word(i)});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  task automatic run_fill(input vec_t v, input int id, output int cycles);
    int idx;
    bit acc;
    idx          = 0;
    start        = 1'b1;
    len_in       = v.len;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    cycle();
    start  = 1'b0;
    cycles = 1;
    check($sformatf("v%0d_done_after_start", id), done, v.exp_writes == 0);
    check($sformatf("v%0d_ready_after_start", id), bus.in_ready, v.exp_writes != 0);
    check($sformatf("v%0d_sum_cleared", id), checksum, 0);
    while (done !== 1'b1 && cycles < 1200) begin
      bus.in_valid = (cycles <= 8) ? v.pat[cycles-1] : 1'b1;
      bus.in_data  = word(idx);
      start        = (cycles == v.restart_at);
      len_in       = start ? 32'd1 : v.len;
      acc          = (bus.in_ready === 1'b1) && bus.in_valid;
      cycle();
      start = 1'b0;
      cycles++;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t tbl[7];

  initial begin
    int cyc;
    int w0;

    tbl[0] = '{32'd4,    {32'd4, 32'd3, 32'd2, 32'd1},                8'hFF,        0, 4,    32'd10,        6};
    tbl[1] = '{32'd3,    {32'd0, 32'd9, 32'd7, 32'd5},                8'b1111_1001, 0, 3,    32'd21,        7};
    tbl[2] = '{32'd0,    {32'd0, 32'd0, 32'd0, 32'd0},                8'hFF,        0, 0,    32'd0,         1};
    tbl[3] = '{32'd2,    {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF},        8'hFF,        0, 2,    32'h0000_0001, 4};
    tbl[4] = '{32'd4,    {32'd400, 32'd300, 32'd200, 32'd100},        8'hF6,        0, 4,    32'd1000,      8};
    tbl[5] = '{32'd4,    {32'h23, 32'h22, 32'h21, 32'h20},            8'hFF,        2, 4,    32'h86,        6};
    tbl[6] = '{32'd5000, {32'd1, 32'd1, 32'd1, 32'd1},                8'hFF,        0, 1024, 32'h0047_BDFE, 1026};

    rst          = 1'b1;
    start        = 1'b0;
    len_in       = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    cur_data     = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_we", bus.we, 0);
    check("rst_addr", bus.write_addr, 0);
    check("rst_data", bus.write_data, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    cycle();
    check("idle_in_ready", bus.in_ready, 0);

    // Reset in the middle of an 8-word fill, after three accepts.
    cur_data = {32'h13, 32'h12, 32'h11, 32'h10};
    push_exp(3);
    start  = 1'b1;
    len_in = 32'd8;
    cycle();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = word(i);
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_we", bus.we, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_addr", bus.write_addr, 0);
    check("midrst_data", bus.write_data, 0);
    check("midrst_done", done, 0);
    check("midrst_checksum", checksum, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_writes_seen", 32'(exp_q.size()), 0);
    @(negedge clk);
    rst = 1'b0;
    w0  = n_writes;
    repeat (3) begin
      cycle();
      check("post_rst_in_ready", bus.in_ready, 0);
    end
    check("post_rst_no_writes", 32'(n_writes - w0), 0);
    bus.in_valid = 1'b0;

    for (int v = 0; v < 7; v++) begin
      cur_data = tbl[v].data;
      push_exp(tbl[v].exp_writes);
      w0 = n_writes;
      run_fill(tbl[v], v, cyc);
      check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(tbl[v].exp_cycles));
      check($sformatf("v%0d_done", v), done, 1);
      check($sformatf("v%0d_checksum", v), checksum, tbl[v].exp_sum);
      check($sformatf("v%0d_in_ready_low", v), bus.in_ready, 0);
      check($sformatf("v%0d_we_low", v), bus.we, 0);
      check($sformatf("v%0d_state", v), dbg_state, ST_DONE);
      check($sformatf("v%0d_write_count", v), 32'(n_writes - w0), 32'(tbl[v].exp_writes));
      check($sformatf("v%0d_exp_drained", v), 32'(exp_q.size()), 0);
      exp_q.delete();
      bus.in_valid = 1'b1;
      repeat (2) cycle();
      bus.in_valid = 1'b0;
      check($sformatf("v%0d_done_held", v), done, 1);
      check($sformatf("v%0d_checksum_held", v), checksum, tbl[v].exp_sum);
      check($sformatf("v%0d_no_late_writes", v), 32'(n_writes - w0), 32'(tbl[v].exp_writes));
      for (int i = 0; i < tbl[v].exp_writes; i++) begin
        if (i < 4 || i == tbl[v].exp_writes - 1)
          check($sformatf("v%0d_ram_%0d", v, i), mem[i], word(i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fill_writer.md
# ram_fill_writer

Streaming writer that fills a synchronous single-port RAM from a valid/ready data stream, one word per accepted beat, at consecutive addresses from 0. It is the write-side counterpart of the accumulator readers: it loads test data into the memory they later read, and keeps a modular running sum of everything written so the result can be checked against the reader's accumulation. It sits between a data source (button/UART/pattern generator) and the RAM write port, in the same clock domain.

## Interface
- AWIDTH, 10, RAM address width; capacity 2^AWIDTH words
- DWIDTH, 32, data width of stream, RAM and checksum
- clk  in  1  system clock (CLK_125MHZ_FPGA at top level)
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begins a fill when IDLE or DONE
- len  in  32  number of words to write; sampled on accepted start
- in_data  in  DWIDTH  stream data
- in_valid  in  1  stream data valid
- in_ready  out  1  writer accepts a beat this cycle
- we  out  1  RAM write enable (registered)
- write_addr  out  AWIDTH  RAM write address (registered)
- write_data  out  DWIDTH  RAM write data (registered)
- done  out  1  fill complete, all writes committed
- checksum  out  DWIDTH  sum mod 2^DWIDTH of all words written in current fill

## Operation
- States: IDLE, WRITE, DONE. Reset -> IDLE.
- IDLE/DONE + start: latch len_eff = min(len, 2^AWIDTH) into an AWIDTH+1-bit register; clear word count, checksum, done; -> WRITE. If len_eff == 0, -> DONE directly (no writes).
- start in WRITE: ignored. start in IDLE/DONE without a fill pending otherwise has no effect beyond the above.
- WRITE: in_ready = 1 while count < len_eff. Beat accepted when in_valid && in_ready. On accept: write_addr <= count[AWIDTH-1:0], write_data <= in_data, we <= 1, checksum <= checksum + in_data (wraps), count <= count + 1. No accept: we <= 0.
- When the accept of word len_eff-1 occurs, count reaches len_eff, in_ready drops next cycle; -> DONE one cycle after the last we pulse.
- DONE: done = 1, in_ready = 0, we = 0, checksum held. Outputs stable until start or rst.
- Addresses never wrap within a fill; len > 2^AWIDTH is clamped, so last address is 2^AWIDTH-1.
- rst at any time (including mid-fill): state IDLE, all outputs 0, count/len_eff/checksum cleared; partially written RAM contents are left as-is.

## Timing
- Reset values: in_ready 0, we 0, write_addr 0, write_data 0, done 0, checksum 0.
- in_ready is a registered-state decode (no combinational path from in_valid).
- Accept at cycle t -> we/addr/data valid cycle t+1 -> RAM commits at end of t+1.
- checksum includes beat t from cycle t+1.
- Last accept at t -> last we at t+1 -> done = 1 from t+2.
- start at t (len_eff > 0) -> in_ready = 1 from t+1. len_eff == 0 -> done = 1 from t+1.
- Throughput: one word per cycle with in_valid held high; fill of N words takes N+2 cycles start-to-done.
- in_valid stalls insert bubbles (we = 0) with no other effect.

## Structure
- Shared package/header: state encoding localparams (IDLE, WRITE, DONE), capacity constant 2^AWIDTH.
- State, count, len_eff, checksum and output registers built from the existing REGISTER_CE/REGISTER_R_CE primitives; no further sub-module. Top-level pairing with SYNC_RAM is done in the z1top wrapper, not here.

## Test plan
- Reset mid-fill: start len=8, assert rst after 3 accepts -> all outputs 0 immediately, in_ready 0, subsequent in_valid ignored until next start.
- Basic fill: start len=4, in_data 1,2,3,4 back-to-back -> we at addrs 0..3 with data 1..4 on consecutive cycles, done at 2 cycles after last accept, checksum 10; RAM readback matches.
- Backpressure/bubbles: len=3, in_valid toggling 1,0,0,1,1 -> exactly 3 writes, we low in bubble cycles, addrs 0,1,2 contiguous, checksum = sum of accepted words.
- Zero and clamp: len=0 -> done next cycle, no we; len=5000 with AWIDTH=10 -> exactly 1024 writes, last addr 1023, in_ready low after 1024th accept.
- Checksum wrap: len=2, data 32'hFFFF_FFFF and 32'h0000_0002 -> checksum 32'h0000_0001.
- Start handling: start during WRITE ignored (count/addr unaffected); start in DONE restarts at addr 0 with done and checksum cleared.
